// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_unit
// Purpose  : Registered ALU with a valid/ready handshake on both sides and
//            registered NZCV flags. Provides AND, OR, ADD, SUB, XOR and SHL
//            with a one-cycle latency. MUL is an unsigned radix-2 shift-add
//            that takes WIDTH cycles. Opcode 111 is reserved and returns zero.
// Ports    : clk, rst             - clock, asynchronous active-high reset
//            in_valid / in_ready  - operand handshake (accept = both high)
//            A_num, B_num         - operands, WIDTH bits
//            ALUControl           - 3-bit opcode
//            out_valid / out_ready- result handshake
//            result               - registered result, WIDTH bits
//            N_flag, Z_flag, C_flag, V_flag - registered flags
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_num,
    input  logic [WIDTH-1:0] B_num,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             N_flag,
    output logic             Z_flag,
    output logic             C_flag,
    output logic             V_flag
);

    localparam int c_SHAMT_W = $clog2(WIDTH);
    localparam int c_CNT_W   = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH - 1);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SHL = 3'b101;
    localparam logic [2:0] c_OP_MUL = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_result;
    logic                   r_n, r_z, r_c, r_v;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;

    logic                   w_accept;
    logic [WIDTH:0]         w_add;
    logic [WIDTH:0]         w_sub;
    logic [WIDTH:0]         w_shl;
    logic [c_SHAMT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]       w_alu_res;
    logic                   w_alu_c, w_alu_v;
    logic [2*WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]       w_fin_res;
    logic                   w_fin_c, w_fin_v;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid & in_ready;

    assign result = r_result;
    assign N_flag = r_n;
    assign Z_flag = r_z;
    assign C_flag = r_c;
    assign V_flag = r_v;

    // Single-cycle operations, evaluated directly on the live inputs so the
    // result can be registered on the accepting edge.
    always_comb begin
        w_add     = {1'b0, A_num} + {1'b0, B_num};
        w_sub     = {1'b0, A_num} + {1'b0, ~B_num} + {{WIDTH{1'b0}}, 1'b1};
        w_shamt   = B_num[c_SHAMT_W-1:0];
        // One extra bit on top catches the last bit shifted out; it is zero
        // when the amount is zero or exceeds WIDTH.
        w_shl     = {1'b0, A_num} << w_shamt;
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (ALUControl)
            c_OP_AND: w_alu_res = A_num & B_num;
            c_OP_OR:  w_alu_res = A_num | B_num;
            c_OP_XOR: w_alu_res = A_num ^ B_num;
            c_OP_ADD: begin
                w_alu_res = w_add[WIDTH-1:0];
                w_alu_c   = w_add[WIDTH];
                w_alu_v   = (A_num[WIDTH-1] == B_num[WIDTH-1]) &
                            (w_add[WIDTH-1] != A_num[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_alu_res = w_sub[WIDTH-1:0];
                w_alu_c   = w_sub[WIDTH];
                w_alu_v   = (A_num[WIDTH-1] != B_num[WIDTH-1]) &
                            (w_sub[WIDTH-1] != A_num[WIDTH-1]);
            end
            c_OP_SHL: begin
                w_alu_res = w_shl[WIDTH-1:0];
                w_alu_c   = w_shl[WIDTH];
            end
            default: begin
                w_alu_res = '0;
            end
        endcase
    end

    // Shift-add step: the multiplicand moves left and the multiplier right,
    // so bit 0 of the multiplier always selects the current partial product.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {2*WIDTH{1'b0}});

    always_comb begin
        if (r_state == S_MUL) begin
            w_fin_res = w_acc_next[WIDTH-1:0];
            w_fin_c   = |w_acc_next[2*WIDTH-1:WIDTH];
            w_fin_v   = 1'b0;
        end else begin
            w_fin_res = w_alu_res;
            w_fin_c   = w_alu_c;
            w_fin_v   = w_alu_v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == '0) begin
                        r_result <= w_fin_res;
                        r_n      <= w_fin_res[WIDTH-1];
                        r_z      <= ~|w_fin_res;
                        r_c      <= w_fin_c;
                        r_v      <= w_fin_v;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (ALUControl == c_OP_MUL) begin
                            r_state  <= S_MUL;
                            r_cnt    <= c_CNT_INIT;
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, A_num};
                            r_mplier <= B_num;
                        end else begin
                            r_result <= w_fin_res;
                            r_n      <= w_fin_res[WIDTH-1];
                            r_z      <= ~|w_fin_res;
                            r_c      <= w_fin_c;
                            r_v      <= w_fin_v;
                            r_state  <= S_DONE;
                        end
                    end else if ((r_state != S_DONE) || out_ready) begin
                        // Result consumed, or recovery from an unused encoding.
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_unit
// Purpose  : Self-checking bench for alu_seq_unit. A WIDTH=4 instance runs
//            directed cases (flags, latency, back-pressure, reset mid-MUL);
//            a WIDTH=8 instance runs random back-to-back traffic. Expected
//            results are queued on accept and compared on output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

    logic       clk = 1'b0;
    logic       rst;

    logic       iv4, ir4, ov4, or4, n4, z4, c4, v4;
    logic [3:0] a4, b4, res4;
    logic [2:0] op4;

    logic       iv8, ir8, ov8, or8, n8, z8, c8, v8;
    logic [7:0] a8, b8, res8;
    logic [2:0] op8;

    int checks = 0;
    int errors = 0;

    logic [11:0] q4[$];
    logic [11:0] q8[$];

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .A_num(a4), .B_num(b4), .ALUControl(op4),
        .out_valid(ov4), .out_ready(or4), .result(res4),
        .N_flag(n4), .Z_flag(z4), .C_flag(c4), .V_flag(v4)
    );

    alu_seq_unit #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .A_num(a8), .B_num(b8), .ALUControl(op8),
        .out_valid(ov8), .out_ready(or8), .result(res8),
        .N_flag(n8), .Z_flag(z8), .C_flag(c8), .V_flag(v8)
    );

    // Reference model: returns {result[7:0], N, Z, C, V} for width w.
    function automatic logic [11:0] model(input int w, input logic [2:0] op,
                                          input logic [7:0] ai, input logic [7:0] bi);
        int   a, b, mask, msb, r, s, amt;
        logic n, z, c, v;
        mask = (1 << w) - 1;
        a    = int'(ai) & mask;
        b    = int'(bi) & mask;
        msb  = w - 1;
        r = 0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd4: r = a ^ b;
            3'd2: begin
                s = a + b;
                r = s & mask;
                c = (s > mask);
                v = (a[msb] == b[msb]) && (r[msb] != a[msb]);
            end
            3'd3: begin
                r = (a - b) & mask;
                c = (a >= b);
                v = (a[msb] != b[msb]) && (r[msb] != a[msb]);
            end
            3'd5: begin
                amt = b & (w - 1);
                r   = (a << amt) & mask;
                c   = (amt == 0) ? 1'b0 : a[w - amt];
            end
            3'd6: begin
                s = a * b;
                r = s & mask;
                c = (s > mask);
            end
            default: r = 0;
        endcase
        n = r[msb];
        z = (r == 0);
        return {r[7:0], n, z, c, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluate both handshakes away from the edge, then advance to the next
    // falling edge. Accepts push the model result; output handshakes pop it.
    task automatic tick();
        logic [11:0] e;
        #1;
        if (iv4 && ir4) q4.push_back(model(4, op4, {4'b0, a4}, {4'b0, b4}));
        if (iv8 && ir8) q8.push_back(model(8, op8, a8, b8));
        if (ov4 && or4) begin
            if (q4.size() > 0) e = q4.pop_front();
            else               e = 12'hxxx;
            chk("w4_out", 32'({4'b0, res4, n4, z4, c4, v4}), 32'(e));
        end
        if (ov8 && or8) begin
            if (q8.size() > 0) e = q8.pop_front();
            else               e = 12'hxxx;
            chk("w8_out", 32'({res8, n8, z8, c8, v8}), 32'(e));
        end
        @(negedge clk);
    endtask

    task automatic do_op4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        op4 = op; a4 = a; b4 = b; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        #1 chk("lat1", 32'(ov4), 32'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ops[7];
        logic [3:0] as[7];
        logic [3:0] bs[7];
        ops = '{3'd3, 3'd3, 3'd3, 3'd0, 3'd1, 3'd5, 3'd7};
        as  = '{4'hF, 4'h8, 4'h3, 4'h7, 4'hF, 4'h9, 4'h5};
        bs  = '{4'h7, 4'h1, 4'h3, 4'h2, 4'hF, 4'h1, 4'h6};

        rst = 1'b1;
        iv4 = 1'b0; or4 = 1'b1; op4 = '0; a4 = '0; b4 = '0;
        iv8 = 1'b0; or8 = 1'b1; op8 = '0; a8 = '0; b8 = '0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_result", 32'(res4), 32'd0);
        chk("rst_flags", 32'({n4, z4, c4, v4}), 32'd0);
        chk("rst_out_valid", 32'({ov4, ov8}), 32'd0);
        chk("rst_in_ready", 32'({ir4, ir8}), 32'b11);
        @(negedge clk);
        rst = 1'b0;

        // ADD 0xE+0xE -> 0xC, N=1 Z=0 C=1 V=0, one cycle latency
        op4 = 3'd2; a4 = 4'hE; b4 = 4'hE; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        #1;
        chk("add_lat", 32'(ov4), 32'd1);
        chk("add_res", 32'(res4), 32'hC);
        chk("add_flags", 32'({n4, z4, c4, v4}), 32'b1010);
        tick();

        // Remaining single-cycle directed ops
        for (int i = 0; i < 7; i++) do_op4(ops[i], as[i], bs[i]);

        // MUL 0x7*0x3 -> 0x5, C=1; busy 4 cycles; valid 5 cycles after accept
        op4 = 3'd6; a4 = 4'h7; b4 = 4'h3; iv4 = 1'b1;
        tick();
        iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("mul_busy_ready", 32'(ir4), 32'd0);
            chk("mul_busy_valid", 32'(ov4), 32'd0);
            tick();
        end
        #1;
        chk("mul_lat", 32'(ov4), 32'd1);
        chk("mul_res", 32'(res4), 32'h5);
        chk("mul_carry", 32'(c4), 32'd1);
        tick();

        // Back-pressure: ADD 5+6 held for 3 cycles (0xB, N=1 Z=0 C=0 V=1)
        or4 = 1'b0;
        op4 = 3'd2; a4 = 4'h5; b4 = 4'h6; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_valid", 32'(ov4), 32'd1);
            chk("bp_ready", 32'(ir4), 32'd0);
            chk("bp_hold", 32'({res4, n4, z4, c4, v4}), 32'hB9);
            tick();
        end
        // Release with a simultaneous new op: accepted the same cycle
        or4 = 1'b1;
        op4 = 3'd0; a4 = 4'hF; b4 = 4'h3; iv4 = 1'b1;
        #1 chk("bp_accept", 32'(ir4), 32'd1);
        tick();
        iv4 = 1'b0;
        #1;
        chk("b2b_valid", 32'(ov4), 32'd1);
        chk("b2b_res", 32'(res4), 32'h3);
        tick();

        // Reset pulse during MUL cycle 2: aborted, no output
        op4 = 3'd6; a4 = 4'hF; b4 = 4'hF; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rmul_valid", 32'(ov4), 32'd0);
        chk("rmul_result", 32'(res4), 32'd0);
        chk("rmul_ready", 32'(ir4), 32'd1);
        q4.delete();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1 chk("rmul_no_stale", 32'(ov4), 32'd0);
            tick();
        end

        // WIDTH=8 random traffic with random back-pressure
        for (int k = 0; k < 300; k++) begin
            iv8 = ($urandom_range(0, 3) != 0);
            op8 = 3'($urandom_range(0, 7));
            a8  = 8'($urandom_range(0, 255));
            b8  = 8'($urandom_range(0, 255));
            or8 = ($urandom_range(0, 4) != 0);
            tick();
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        for (int k = 0; k < 40 && (q8.size() != 0 || ov8); k++) tick();
        chk("w8_drain", 32'(q8.size()), 32'd0);
        chk("w8_idle", 32'(ov8), 32'd0);
        chk("w4_drain", 32'(q4.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
